spi_master_core: RTL and testbench

- Single-byte, full-duplex SPI master.
- Shifts an 8-bit word out on mosi and captures 8 bits from miso, MSB first.
- Supports all four CPOL/CPHA modes and drives an 8-bit active-low slave-select bus.
- Sits between a CPU peripheral register block (din/dout/write/busy) and external SPI pins.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_gen.sv | 72 +++++++
 rtl/spi_master_core.sv | 139 +++++++++++++
 tb/tb_spi_master_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the single-byte SPI master.
package spi_pkg;

    // Controller state encoding
    typedef logic [1:0] spi_state_t;
    localparam spi_state_t ST_IDLE = 2'd0;
    localparam spi_state_t ST_XFER = 2'd1;
    localparam spi_state_t ST_DONE = 2'd2;

    localparam logic [7:0] SS_IDLE = 8'hFF;
    localparam int         BITS    = 8;
    localparam int         EDGES   = 2 * BITS;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: half-period down-counter plus edge counter.
// Produces one-cycle leading/trailing strobes coincident with the clk edge
// that toggles sck, a flag for the final sck edge, and an end strobe one
// half-period after the final edge.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic cpol_i,
    output logic sck_o,
    output logic lead_o,
    output logic trail_o,
    output logic last_edge_o,
    output logic end_o
);

    localparam int              TW     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [TW-1:0]   RELOAD = TW'(HALF_PERIOD - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    edge_q, edge_d;
    logic          sck_q, sck_d;
    logic          tick;
    logic          sck_edge;

    assign tick     = run_i && (timer_q == '0);
    assign sck_edge = tick && (edge_q < 5'(EDGES));

    assign lead_o      = sck_edge && !edge_q[0];
    assign trail_o     = sck_edge &&  edge_q[0];
    assign last_edge_o = sck_edge && (edge_q == 5'(EDGES - 1));
    assign end_o       = tick && (edge_q == 5'(EDGES));
    assign sck_o       = sck_q;

    // Next-state: hold sck at cpol and rearm while stopped, otherwise count half-periods
    always_comb begin
        timer_d = timer_q;
        edge_d  = edge_q;
        sck_d   = sck_q;
        if (!run_i) begin
            timer_d = RELOAD;
            edge_d  = '0;
            sck_d   = cpol_i;
        end else if (tick) begin
            timer_d = RELOAD;
            edge_d  = edge_q + 5'd1;
            if (sck_edge) begin
                sck_d = ~sck_q;
            end
        end else begin
            timer_d = timer_q - 1'b1;
        end
    end

    // Timer, edge counter and sck registers
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= RELOAD;
            edge_q  <= '0;
            sck_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            edge_q  <= edge_d;
            sck_q   <= sck_d;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Single-byte full-duplex SPI master, MSB first, all four CPOL/CPHA modes.
//
//   state | meaning
//   IDLE  | ss deasserted, sck follows cpol, waiting for write
//   XFER  | 16 sck edges plus a trailing half-period, shifting tx/rx
//   DONE  | one busy-low cycle, dout already updated; a held write restarts here
module spi_master_core
    import spi_pkg::*;
#(
    parameter int         HALF_PERIOD = 1,
    parameter logic [7:0] SS_MASK     = 8'hFE
) (
    input  logic       clk,
    input  logic       reset,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] ss,
    input  logic       write,
    output logic       busy,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       cpol,
    input  logic       cpha
);

    spi_state_t state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] ss_q, ss_d;
    logic [7:0] dout_q, dout_d;
    logic       cpha_q, cpha_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;

    logic lead, trail, last_edge, xfer_end;
    logic sample, drive;

    // The sck register loads cpol at the start edge and only toggles during
    // XFER, so it carries the latched clock polarity for the whole transfer.
    spi_clk_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_gen (
        .clk        (clk),
        .reset      (reset),
        .run_i      (state_q == ST_XFER),
        .cpol_i     (cpol),
        .sck_o      (sck),
        .lead_o     (lead),
        .trail_o    (trail),
        .last_edge_o(last_edge),
        .end_o      (xfer_end)
    );

    assign sample = cpha_q ? trail : lead;
    assign drive  = cpha_q ? lead  : (trail && !last_edge);

    // Transfer sequencing and shift datapath
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ss_d    = ss_q;
        dout_d  = dout_q;
        cpha_d  = cpha_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                mosi_d  = 1'b0;
                ss_d    = SS_IDLE;
                busy_d  = 1'b0;
                if (write) begin
                    state_d = ST_XFER;
                    cpha_d  = cpha;
                    busy_d  = 1'b1;
                    ss_d    = SS_MASK;
                    // cpha=0 presents bit 7 before the first edge, so the
                    // shifter starts one bit ahead and every drive uses tx[7]
                    if (cpha) begin
                        tx_d = din;
                    end else begin
                        tx_d   = {din[6:0], 1'b0};
                        mosi_d = din[7];
                    end
                end
            end
            ST_XFER: begin
                if (sample) begin
                    rx_d = {rx_q[6:0], miso};
                end
                if (drive) begin
                    mosi_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (xfer_end) begin
                    state_d = ST_DONE;
                    dout_d  = rx_q;
                    busy_d  = 1'b0;
                    ss_d    = SS_IDLE;
                    mosi_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            ss_q    <= SS_IDLE;
            dout_q  <= '0;
            cpha_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ss_q    <= ss_d;
            dout_q  <= dout_d;
            cpha_q  <= cpha_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
        end
    end

    assign mosi = mosi_q;
    assign ss   = ss_q;
    assign busy = busy_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: two instances (HALF_PERIOD 1 and 4) sharing
// stimulus, a per-transfer timing model, directed cases then random traffic.
module tb_spi_master_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, write, cpol, cpha, loop_en;
    logic [7:0] din, miso_byte;

    wire  [1:0] sck_w, mosi_w, busy_w, miso_w;
    wire  [7:0] ss_w   [2];
    wire  [7:0] dout_w [2];
    logic [1:0] miso_drv;

    // model state, one slot per instance
    bit         m_active [2];
    int         m_c      [2];
    logic       m_cpol   [2];
    logic       m_cpha   [2];
    logic       m_loop   [2];
    logic [7:0] m_din    [2];
    logic [7:0] m_miso   [2];
    logic [7:0] m_dout   [2];
    logic       m_idle_sck [2];
    bit         m_valid = 0;

    // observations
    int         busy_run [2], low_run [2], last_busy [2], low_gap [2];
    int         tog [2], pe [2];
    logic       prev_sck [2];
    logic [7:0] lead [2];

    int errors = 0;
    int checks = 0;

    assign miso_w[0] = m_loop[0] ? mosi_w[0] : miso_drv[0];
    assign miso_w[1] = m_loop[1] ? mosi_w[1] : miso_drv[1];

    spi_master_core #(.HALF_PERIOD(1), .SS_MASK(8'hFE)) dut0 (
        .clk(clk), .reset(reset), .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0]),
        .ss(ss_w[0]), .write(write), .busy(busy_w[0]), .din(din), .dout(dout_w[0]),
        .cpol(cpol), .cpha(cpha));

    spi_master_core #(.HALF_PERIOD(4), .SS_MASK(8'hFE)) dut1 (
        .clk(clk), .reset(reset), .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1]),
        .ss(ss_w[1]), .write(write), .busy(busy_w[1]), .din(din), .dout(dout_w[1]),
        .cpol(cpol), .cpha(cpha));

    function automatic int hp(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int edges(input int i);
        int e;
        e = m_c[i] / hp(i);
        return (e > 16) ? 16 : e;
    endfunction

    task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got=%h want=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    // model: transfer timeline advanced on each rising edge from pre-edge inputs
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_active[i]   = 0;
                m_dout[i]     = 8'h00;
                m_idle_sck[i] = 1'b0;
                m_loop[i]     = 1'b0;
            end else begin
                if (m_active[i]) begin
                    if (m_c[i] == 17 * hp(i)) begin
                        m_active[i] = 0;
                    end else begin
                        m_c[i]++;
                        if (m_c[i] == 17 * hp(i))
                            m_dout[i] = m_loop[i] ? m_din[i] : m_miso[i];
                    end
                end
                if (!m_active[i] && write) begin
                    m_active[i] = 1;
                    m_c[i]      = 0;
                    m_cpol[i]   = cpol;
                    m_cpha[i]   = cpha;
                    m_din[i]    = din;
                    m_miso[i]   = miso_byte;
                    m_loop[i]   = loop_en;
                end
                m_idle_sck[i] = cpol;
            end
        end
        if (reset) m_valid = 1;
    end

    // compare every cycle on the falling edge, then present the next miso bit
    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                logic       eb, es, em;
                logic [7:0] ess;
                int         e, t, s;
                e  = edges(i);
                eb = 1'b0; es = m_idle_sck[i]; em = 1'b0; ess = 8'hFF;
                if (m_active[i]) begin
                    if (m_c[i] < 17 * hp(i)) begin
                        eb  = 1'b1;
                        ess = 8'hFE;
                        es  = m_cpol[i] ^ e[0];
                        if (!m_cpha[i]) begin
                            t  = (e / 2 > 7) ? 7 : e / 2;
                            em = m_din[i][7 - t];
                        end else if (e > 0) begin
                            em = m_din[i][8 - (e + 1) / 2];
                        end
                    end else begin
                        es = m_cpol[i];
                    end
                end
                chk("busy", i, {7'b0, busy_w[i]}, {7'b0, eb});
                chk("ss",   i, ss_w[i], ess);
                chk("sck",  i, {7'b0, sck_w[i]}, {7'b0, es});
                chk("mosi", i, {7'b0, mosi_w[i]}, {7'b0, em});
                chk("dout", i, dout_w[i], m_dout[i]);

                if (busy_w[i]) begin
                    if (busy_run[i] == 0) low_gap[i] = low_run[i];
                    busy_run[i]++;
                    low_run[i] = 0;
                end else begin
                    if (busy_run[i] > 0) last_busy[i] = busy_run[i];
                    busy_run[i] = 0;
                    low_run[i]++;
                end

                if (m_active[i] && m_c[i] == 0) begin
                    lead[i] = 8'h00; tog[i] = 0; pe[i] = 0;
                end else if (m_active[i]) begin
                    if (e != pe[i] && e[0]) lead[i] = {lead[i][6:0], mosi_w[i]};
                    pe[i] = e;
                    if (sck_w[i] !== prev_sck[i]) tog[i]++;
                end
                prev_sck[i] = sck_w[i];

                if (m_active[i] && m_c[i] < 17 * hp(i)) begin
                    s = m_cpha[i] ? e / 2 : (e + 1) / 2;
                    miso_drv[i] = (s < 8) ? m_miso[i][7 - s] : 1'($urandom);
                end else begin
                    miso_drv[i] = 1'($urandom);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!(!m_active[0] && !m_active[1] && busy_w == 2'b00) && k < 400);
        if (k >= 400) begin
            errors++;
            $display("FAIL wait_idle timeout got=busy want=idle");
        end
    endtask

    task automatic wait_busy(input int i, input logic level);
        int k;
        k = 0;
        while (busy_w[i] !== level && k < 200) begin
            step(1);
            k++;
        end
        if (k >= 200) begin
            errors++;
            $display("FAIL wait_busy inst%0d got=%b want=%b", i, busy_w[i], level);
        end
    endtask

    task automatic xfer(input logic p, input logic h, input logic [7:0] d, input logic [7:0] m, input logic lp);
        cpol = p; cpha = h; din = d; miso_byte = m; loop_en = lp;
        step(2);
        write = 1'b1;
        step(1);
        write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; din = 8'h00; cpol = 1'b0; cpha = 1'b0;
        miso_byte = 8'h00; loop_en = 1'b0; miso_drv = 2'b00;
        step(3);
        reset = 1'b0;
        step(2);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, {7'b0, busy_w[i]}, 8'h00);
            chk("rst_ss",   i, ss_w[i], 8'hFF);
            chk("rst_sck",  i, {7'b0, sck_w[i]}, 8'h00);
            chk("rst_dout", i, dout_w[i], 8'h00);
        end

        // mode 0
        xfer(1'b0, 1'b0, 8'h2A, 8'h95, 1'b0);
        step(4);
        chk("m0_ss_mid", 0, ss_w[0], 8'hFE);
        wait_idle();
        chk("m0_lead", 0, lead[0], 8'h2A);
        chk("m0_dout", 0, dout_w[0], 8'h95);
        chk("m0_dout", 1, dout_w[1], 8'h95);
        chk("m0_busylen", 0, 8'(last_busy[0]), 8'd17);

        // mode 3
        cpol = 1'b1;
        step(2);
        chk("m3_idle_sck", 0, {7'b0, sck_w[0]}, 8'h01);
        xfer(1'b1, 1'b1, 8'hC3, 8'hFF, 1'b0);
        wait_idle();
        chk("m3_lead", 0, lead[0], 8'hC3);
        chk("m3_dout", 0, dout_w[0], 8'hFF);

        // modes 1 and 2 with loopback
        xfer(1'b0, 1'b1, 8'hA5, 8'h00, 1'b1);
        wait_idle();
        chk("m1_loop", 0, dout_w[0], 8'hA5);
        chk("m1_loop", 1, dout_w[1], 8'hA5);
        xfer(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
        wait_idle();
        chk("m2_loop", 0, dout_w[0], 8'hA5);
        chk("m2_loop", 1, dout_w[1], 8'hA5);

        // back-to-back with write held, din changed mid-transfer
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1; din = 8'h11;
        step(2);
        write = 1'b1;
        step(6);
        din = 8'h22;
        wait_busy(0, 1'b0);
        chk("b2b_first", 0, dout_w[0], 8'h11);
        wait_busy(0, 1'b1);
        wait_busy(0, 1'b0);
        write = 1'b0;
        chk("b2b_second", 0, dout_w[0], 8'h22);
        chk("b2b_gap", 0, 8'(low_gap[0]), 8'd1);
        wait_idle();

        // reset at sck edge 7
        xfer(1'b0, 1'b0, 8'h2A, 8'h95, 1'b0);
        step(6);
        reset = 1'b1;
        step(1);
        chk("rmid_sck",  0, {7'b0, sck_w[0]}, 8'h00);
        chk("rmid_ss",   0, ss_w[0], 8'hFF);
        chk("rmid_busy", 0, {7'b0, busy_w[0]}, 8'h00);
        chk("rmid_dout", 0, dout_w[0], 8'h00);
        reset = 1'b0;
        xfer(1'b0, 1'b0, 8'h5A, 8'h3C, 1'b0);
        wait_idle();
        chk("post_rst_dout", 0, dout_w[0], 8'h3C);
        chk("post_rst_lead", 0, lead[0], 8'h5A);

        // HALF_PERIOD=4 instance
        xfer(1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
        wait_idle();
        chk("hp4_busylen", 1, 8'(last_busy[1]), 8'd68);
        chk("hp4_dout",    1, dout_w[1], 8'h00);
        chk("hp4_toggles", 1, 8'(tog[1]), 8'd16);

        // random traffic
        repeat (3000) begin
            write = ($urandom_range(0, 5) == 0);
            din   = 8'($urandom);
            if ($urandom_range(0, 15) == 0) cpol = 1'($urandom);
            cpha      = 1'($urandom);
            miso_byte = 8'($urandom);
            loop_en   = 1'($urandom);
            reset     = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset = 1'b0;
        write = 1'b0;
        wait_idle();
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
